// File: rtl/instr_encoder.sv
// RISC-V instruction encoder: packs fields into one of the I/S/B/U/J formats,
// or expands a 32-bit load-immediate into ADDI / LUI / LUI+ADDI beats.
module instr_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        li,
    input  logic [2:0]  ext_op,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr,
    output logic        out_last,
    output logic        range_err
);

    localparam int unsigned DATA_WIDTH = 32;

    localparam logic [2:0] EXTOP_I = 3'd0;
    localparam logic [2:0] EXTOP_U = 3'd1;
    localparam logic [2:0] EXTOP_S = 3'd2;
    localparam logic [2:0] EXTOP_B = 3'd3;
    localparam logic [2:0] EXTOP_J = 3'd4;

    localparam logic [6:0] OP_IMM = 7'h13;
    localparam logic [6:0] OP_LUI = 7'h37;
    localparam logic [DATA_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, EMIT1, EMIT2} state_t;

    state_t                state_q, state_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic                  out_last_q, out_last_d;
    logic                  range_err_q, range_err_d;
    logic [DATA_WIDTH-1:0] beat2_q, beat2_d;
    logic                  two_beats_q, two_beats_d;

    logic                  fits12, fits13, fits21, lo_zero;
    logic [19:0]           hi;
    logic [DATA_WIDTH-1:0] enc_instr, enc_beat2;
    logic                  enc_err, enc_two;

    assign fits12  = (&imm[31:11]) | ~(|imm[31:11]);
    assign fits13  = (&imm[31:12]) | ~(|imm[31:12]);
    assign fits21  = (&imm[31:20]) | ~(|imm[31:20]);
    assign lo_zero = (imm[11:0] == 12'd0);
    // Upper part rounded so that the sign-extended low 12 bits add back correctly
    assign hi      = imm[31:12] + 20'(imm[11]);

    // First-beat encoding (and optional second beat) from the live request fields
    always_comb begin
        enc_instr = NOP_INSTR;
        enc_beat2 = {imm[11:0], rd, 3'd0, rd, OP_IMM};
        enc_err   = 1'b0;
        enc_two   = 1'b0;
        if (li) begin
            if (fits12) begin
                enc_instr = {imm[11:0], 5'd0, 3'd0, rd, OP_IMM};
            end else begin
                enc_instr = {hi, rd, OP_LUI};
                enc_two   = ~lo_zero;
            end
        end else begin
            case (ext_op)
                EXTOP_I: begin
                    enc_instr = {imm[11:0], rs1, funct3, rd, opcode};
                    enc_err   = ~fits12;
                end
                EXTOP_S: begin
                    enc_instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                    enc_err   = ~fits12;
                end
                EXTOP_B: begin
                    enc_instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                    enc_err   = ~fits13 | imm[0];
                end
                EXTOP_U: begin
                    enc_instr = {imm[31:12], rd, opcode};
                    enc_err   = ~lo_zero;
                end
                EXTOP_J: begin
                    enc_instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                    enc_err   = ~fits21 | imm[0];
                end
                default: begin
                    enc_instr = NOP_INSTR;
                    enc_err   = 1'b1;
                end
            endcase
        end
    end

    assign in_ready = (state_q == IDLE) && !rst;

    // Beat sequencing; outputs only change on accept or retire so they hold under stall
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        instr_d     = instr_q;
        out_last_d  = out_last_q;
        range_err_d = range_err_q;
        beat2_d     = beat2_q;
        two_beats_d = two_beats_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d     = EMIT1;
                    out_valid_d = 1'b1;
                    instr_d     = enc_instr;
                    out_last_d  = ~enc_two;
                    range_err_d = enc_err;
                    beat2_d     = enc_beat2;
                    two_beats_d = enc_two;
                end
            end
            EMIT1: begin
                if (out_ready) begin
                    if (two_beats_q) begin
                        state_d     = EMIT2;
                        instr_d     = beat2_q;
                        out_last_d  = 1'b1;
                        range_err_d = 1'b0;
                    end else begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                    end
                end
            end
            EMIT2: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            instr_q     <= '0;
            out_last_q  <= 1'b0;
            range_err_q <= 1'b0;
            beat2_q     <= '0;
            two_beats_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            instr_q     <= instr_d;
            out_last_q  <= out_last_d;
            range_err_q <= range_err_d;
            beat2_q     <= beat2_d;
            two_beats_q <= two_beats_d;
        end
    end

    assign out_valid = out_valid_q;
    assign instr     = instr_q;
    assign out_last  = out_last_q;
    assign range_err = range_err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed vectors plus random requests checked
// against an arithmetic reference model of the encoding rules.
module tb_instr_encoder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        li;
    logic [2:0]  ext_op;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic        out_last;
    logic        range_err;

    int total = 0;
    int bad   = 0;

    int          exp_n;
    logic [31:0] exp_instr [2];
    logic        exp_last  [2];
    logic        exp_err   [2];

    instr_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .li        (li),
        .ext_op    (ext_op),
        .opcode    (opcode),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .funct3    (funct3),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .instr     (instr),
        .out_last  (out_last),
        .range_err (range_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model: expected beats from the encoding rules using plain arithmetic
    task automatic model(input logic l, input logic [2:0] e, input logic [6:0] op,
                         input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [2:0] f3, input logic [31:0] v);
        int          s;
        logic [31:0] hi, lo, base;
        s    = $signed(v);
        lo   = v & 32'hFFF;
        base = (32'(s1) << 15) | (32'(f3) << 12) | 32'(op);
        exp_n = 1;
        exp_last[0] = 1'b1;
        exp_err[0]  = 1'b0;
        exp_last[1] = 1'b1;
        exp_err[1]  = 1'b0;
        exp_instr[1] = 32'h0;
        if (l) begin
            if (s >= -2048 && s <= 2047) begin
                exp_instr[0] = (lo << 20) | (32'(d) << 7) | 32'h13;
            end else begin
                hi = (v + 32'h800) >> 12;
                exp_instr[0] = (hi << 12) | (32'(d) << 7) | 32'h37;
                if (lo != 0) begin
                    exp_n = 2;
                    exp_last[0] = 1'b0;
                    exp_instr[1] = (lo << 20) | (32'(d) << 15) | (32'(d) << 7) | 32'h13;
                end
            end
        end else begin
            case (e)
                3'd0: begin
                    exp_err[0]   = !(s >= -2048 && s <= 2047);
                    exp_instr[0] = (lo << 20) | base | (32'(d) << 7);
                end
                3'd2: begin
                    exp_err[0]   = !(s >= -2048 && s <= 2047);
                    exp_instr[0] = (((v >> 5) & 32'h7F) << 25) | (32'(s2) << 20) | base
                                 | ((v & 32'h1F) << 7);
                end
                3'd3: begin
                    exp_err[0]   = !(s >= -4096 && s <= 4095) || (v[0] == 1'b1);
                    exp_instr[0] = (((v >> 12) & 32'h1) << 31) | (((v >> 5) & 32'h3F) << 25)
                                 | (32'(s2) << 20) | base | (((v >> 1) & 32'hF) << 8)
                                 | (((v >> 11) & 32'h1) << 7);
                end
                3'd1: begin
                    exp_err[0]   = (lo != 0);
                    exp_instr[0] = (v & 32'hFFFFF000) | (32'(d) << 7) | 32'(op);
                end
                3'd4: begin
                    exp_err[0]   = !(s >= -1048576 && s <= 1048575) || (v[0] == 1'b1);
                    exp_instr[0] = (((v >> 20) & 32'h1) << 31) | (((v >> 1) & 32'h3FF) << 21)
                                 | (((v >> 11) & 32'h1) << 20) | (((v >> 12) & 32'hFF) << 12)
                                 | (32'(d) << 7) | 32'(op);
                end
                default: begin
                    exp_err[0]   = 1'b1;
                    exp_instr[0] = 32'h0000_0013;
                end
            endcase
        end
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while (!in_ready && w < 10) begin
            step();
            w++;
        end
        chk("in_ready_idle", 32'(in_ready), 32'd1);
    endtask

    task automatic issue(input logic l, input logic [2:0] e, input logic [6:0] op,
                         input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [2:0] f3, input logic [31:0] v);
        wait_idle();
        li = l; ext_op = e; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; imm = v;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        // Scramble inputs to confirm the request was latched
        li = 1'($urandom); ext_op = 3'($urandom); opcode = 7'($urandom);
        rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
        funct3 = 3'($urandom); imm = $urandom;
    endtask

    // Drain the expected beats with a given number of stall cycles before each retire
    task automatic drain(input int stalls);
        for (int b = 0; b < exp_n; b++) begin
            for (int k = 0; k < stalls; k++) begin
                out_ready = 1'b0;
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_instr", instr, exp_instr[b]);
                chk("stall_last", 32'(out_last), 32'(exp_last[b]));
                chk("stall_in_ready", 32'(in_ready), 32'd0);
                step();
            end
            out_ready = 1'b1;
            chk("beat_valid", 32'(out_valid), 32'd1);
            chk("beat_instr", instr, exp_instr[b]);
            chk("beat_last", 32'(out_last), 32'(exp_last[b]));
            chk("beat_err", 32'(range_err), 32'(exp_err[b]));
            chk("beat_in_ready", 32'(in_ready), 32'd0);
            step();
            out_ready = 1'b0;
        end
        chk("done_valid", 32'(out_valid), 32'd0);
        chk("done_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic        l;
        logic [2:0]  e;
        logic [31:0] v, t;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        li = 1'b0; ext_op = 3'd0; opcode = 7'd0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
        funct3 = 3'd0; imm = 32'd0;
        step();
        step();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_err", 32'(range_err), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        step();

        // Directed vectors with literal expectations
        issue(1'b1, 3'd0, 7'h0, 5'd5, 5'd0, 5'd0, 3'd0, 32'h0000_07FF);
        exp_n = 1; exp_instr[0] = 32'h7FF0_0293; exp_last[0] = 1'b1; exp_err[0] = 1'b0;
        drain(0);

        issue(1'b1, 3'd0, 7'h0, 5'd10, 5'd0, 5'd0, 3'd0, 32'h1234_5FFF);
        exp_n = 2;
        exp_instr[0] = 32'h1234_6537; exp_last[0] = 1'b0; exp_err[0] = 1'b0;
        exp_instr[1] = 32'hFFF5_0513; exp_last[1] = 1'b1; exp_err[1] = 1'b0;
        drain(1);

        issue(1'b1, 3'd0, 7'h0, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0000_1000);
        exp_n = 1; exp_instr[0] = 32'h0000_10B7; exp_last[0] = 1'b1; exp_err[0] = 1'b0;
        drain(0);

        issue(1'b0, 3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'hFFFF_FFFC);
        exp_n = 1; exp_instr[0] = 32'hFE20_8EE3; exp_last[0] = 1'b1; exp_err[0] = 1'b0;
        drain(3);

        issue(1'b0, 3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'h0000_1001);
        model(1'b0, 3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'h0000_1001);
        chk("b_err_flag", 32'(exp_err[0]), 32'd1);
        drain(0);

        issue(1'b0, 3'd6, 7'h33, 5'd3, 5'd4, 5'd5, 3'd1, 32'h0000_0004);
        exp_n = 1; exp_instr[0] = 32'h0000_0013; exp_last[0] = 1'b1; exp_err[0] = 1'b1;
        drain(0);

        // Reset while the first LUI beat retires: the ADDI beat must never appear
        issue(1'b1, 3'd0, 7'h0, 5'd10, 5'd0, 5'd0, 3'd0, 32'h1234_5FFF);
        chk("abort_beat1", instr, 32'h1234_6537);
        out_ready = 1'b1;
        rst = 1'b1;
        step();
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_instr", instr, 32'd0);
        chk("abort_last", 32'(out_last), 32'd0);
        chk("abort_in_ready_rst", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("abort_quiet", 32'(out_valid), 32'd0);
        end
        out_ready = 1'b0;

        // Random requests against the reference model
        for (int n = 0; n < 80; n++) begin
            t = $urandom;
            case ($urandom_range(0, 3))
                0: v = $urandom;
                1: v = {{20{t[11]}}, t[11:0]};
                2: v = $urandom & 32'hFFFF_F000;
                default: v = {{11{t[20]}}, t[20:0]};
            endcase
            if ($urandom_range(0, 3) == 0) v = v & 32'hFFFF_FFFE;
            l = 1'($urandom_range(0, 1));
            e = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            begin
                logic [6:0] op;
                logic [4:0] d, s1, s2;
                logic [2:0] f3;
                op = 7'($urandom); d = 5'($urandom); s1 = 5'($urandom);
                s2 = 5'($urandom); f3 = 3'($urandom);
                model(l, e, op, d, s1, s2, f3, v);
                issue(l, e, op, d, s1, s2, f3, v);
                drain($urandom_range(0, 2));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
